// File: rtl/sensor_line_capture_if.sv
// Interface bundling the sensor capture handshake, pixel stream and read port.
// The slave modport is the capture block; the master modport is the
// surrounding system (SI source, ADC, and line consumer).
`timescale 1ns/1ps
interface sensor_line_capture_if #(
  parameter int IDX_W = 7,
  parameter int ADC_W = 8
);
  logic             si;
  logic             pix_valid;
  logic [ADC_W-1:0] pix_data;
  logic             frame_valid;
  logic             frame_ack;
  logic [IDX_W-1:0] rd_addr;
  logic [ADC_W-1:0] rd_data;
  logic [IDX_W:0]   pix_count;
  logic             overrun;
  logic             sync_err;
  logic [ADC_W-1:0] peak_val;
  logic [IDX_W-1:0] peak_idx;

  modport slave (
    input  si, pix_valid, pix_data, frame_ack, rd_addr,
    output frame_valid, rd_data, pix_count, overrun, sync_err, peak_val, peak_idx
  );

  modport master (
    output si, pix_valid, pix_data, frame_ack, rd_addr,
    input  frame_valid, rd_data, pix_count, overrun, sync_err, peak_val, peak_idx
  );
endinterface

// File: rtl/sensor_line_capture.sv
// Linear-sensor line capture: waits for the SI pulse, stores the following
// NUM_PIXELS ADC samples into a line buffer, then holds the line for a
// downstream consumer via frame_valid/frame_ack and a 1-cycle read port.
// Optional brightest-pixel tracking is enabled by SENSOR_LINE_PEAK_EN.
`timescale 1ns/1ps
module sensor_line_capture #(
  parameter int NUM_PIXELS = 128,
  parameter int IDX_W      = 7,
  parameter int ADC_W      = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  sensor_line_capture_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, CAPTURE, READY} state_t;

  localparam logic [IDX_W:0] C_FULL = NUM_PIXELS[IDX_W:0];
  localparam logic [IDX_W:0] C_LAST = NUM_PIXELS[IDX_W:0] - 1'b1;

  state_t           r_state;
  state_t           w_state_next;
  logic [ADC_W-1:0] r_buf [NUM_PIXELS];
  logic [IDX_W:0]   r_count;
  logic             r_frame_valid;
  logic             r_overrun;
  logic             r_sync_err;
  logic [ADC_W-1:0] r_rd_data;
  logic             w_wr_en;
  logic             w_cnt_clr;
  logic             w_set_sync;
  logic             w_set_ovr;

  // State register; reset abandons any partial line.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_next;
  end

  // Next-state and control decode. SI always wins over a coincident pixel.
  always_comb begin
    w_state_next = r_state;
    w_wr_en      = 1'b0;
    w_cnt_clr    = 1'b0;
    w_set_sync   = 1'b0;
    w_set_ovr    = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.si) begin
          w_state_next = CAPTURE;
          w_cnt_clr    = 1'b1;
        end
      end
      CAPTURE: begin
        if (bus.si) begin
          // Resynchronise on an unexpected SI and start the line over.
          w_cnt_clr  = 1'b1;
          w_set_sync = 1'b1;
        end else if (bus.pix_valid) begin
          w_wr_en = 1'b1;
          if (r_count == C_LAST) w_state_next = READY;
        end
      end
      READY: begin
        // An SI here is never used to start a line; it only flags overrun.
        if (bus.si)        w_set_ovr    = 1'b1;
        if (bus.frame_ack) w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  // Pixel counter, frame_valid and sticky error flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count       <= '0;
      r_frame_valid <= 1'b0;
      r_overrun     <= 1'b0;
      r_sync_err    <= 1'b0;
    end else begin
      if (w_cnt_clr)
        r_count <= '0;
      else if (w_wr_en && (r_count != C_FULL))
        r_count <= r_count + 1'b1;
      r_frame_valid <= (w_state_next == READY);
      if (w_set_ovr)  r_overrun  <= 1'b1;
      if (w_set_sync) r_sync_err <= 1'b1;
    end
  end

  // Line buffer write port; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (w_wr_en) r_buf[r_count[IDX_W-1:0]] <= bus.pix_data;
  end

  // Registered read port with zero for addresses past the line length.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      r_rd_data <= '0;
    else if ({1'b0, bus.rd_addr} < C_FULL)
      r_rd_data <= r_buf[bus.rd_addr];
    else
      r_rd_data <= '0;
  end

  assign bus.frame_valid = r_frame_valid;
  assign bus.pix_count   = r_count;
  assign bus.overrun     = r_overrun;
  assign bus.sync_err    = r_sync_err;
  assign bus.rd_data     = r_rd_data;

`ifdef SENSOR_LINE_PEAK_EN
  logic [ADC_W-1:0] r_peak_val;
  logic [IDX_W-1:0] r_peak_idx;

  // Running maximum; strict compare keeps the lowest index on ties.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_peak_val <= '0;
      r_peak_idx <= '0;
    end else if (w_cnt_clr) begin
      r_peak_val <= '0;
      r_peak_idx <= '0;
    end else if (w_wr_en && ((r_count == '0) || (bus.pix_data > r_peak_val))) begin
      r_peak_val <= bus.pix_data;
      r_peak_idx <= r_count[IDX_W-1:0];
    end
  end

  assign bus.peak_val = r_peak_val;
  assign bus.peak_idx = r_peak_idx;
`else
  assign bus.peak_val = '0;
  assign bus.peak_idx = '0;
`endif

endmodule

// File: tb/tb_sensor_line_capture.sv
// Directed-sequence bench with randomized pixel data and gaps, checked
// against a queue-based line model of the capture protocol.
`timescale 1ns/1ps
module tb_sensor_line_capture;
  localparam int NUM_PIXELS = 128;
  localparam int IDX_W      = 7;
  localparam int ADC_W      = 8;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  sensor_line_capture_if #(.IDX_W(IDX_W), .ADC_W(ADC_W)) bus ();

  sensor_line_capture #(
    .NUM_PIXELS(NUM_PIXELS), .IDX_W(IDX_W), .ADC_W(ADC_W)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_err = 0;
  int n_chk = 0;

  // Line model: pixels accepted since the last usable SI, plus the held line.
  bit m_capturing, m_have_line, m_ovr, m_sync;
  int m_cnt;
  int q[$];
  int m_line [NUM_PIXELS];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_peak(output int pv, output int pi);
    pv = -1;
    pi = 0;
    for (int i = 0; i < NUM_PIXELS; i++)
      if (m_line[i] > pv) begin
        pv = m_line[i];
        pi = i;
      end
  endtask

  task automatic model_apply(input bit si, input bit pv, input int d, input bit ack);
    if (m_have_line) begin
      if (si)  m_ovr = 1'b1;
      if (ack) m_have_line = 1'b0;
    end else if (si) begin
      if (m_capturing) m_sync = 1'b1;
      m_capturing = 1'b1;
      q.delete();
      m_cnt = 0;
    end else if (m_capturing && pv) begin
      q.push_back(d);
      m_cnt = q.size();
      if (q.size() == NUM_PIXELS) begin
        for (int i = 0; i < NUM_PIXELS; i++) m_line[i] = q[i];
        m_have_line = 1'b1;
        m_capturing = 1'b0;
      end
    end
  endtask

  task automatic check_outputs();
    check("frame_valid", bus.frame_valid, m_have_line);
    check("pix_count", bus.pix_count, m_cnt);
    check("overrun", bus.overrun, m_ovr);
    check("sync_err", bus.sync_err, m_sync);
`ifdef SENSOR_LINE_PEAK_EN
    if (m_have_line) begin
      int pv, pi;
      model_peak(pv, pi);
      check("peak_val", bus.peak_val, pv);
      check("peak_idx", bus.peak_idx, pi);
    end
`else
    check("peak_val", bus.peak_val, 0);
    check("peak_idx", bus.peak_idx, 0);
`endif
  endtask

  // One clock of stimulus; outputs sampled 1 ns after the edge.
  task automatic cyc(input bit si, input bit pv, input int d, input bit ack);
    bus.si        = si;
    bus.pix_valid = pv;
    bus.pix_data  = d[ADC_W-1:0];
    bus.frame_ack = ack;
    model_apply(si, pv, d & 255, ack);
    @(posedge clk);
    #1;
    bus.si        = 1'b0;
    bus.pix_valid = 1'b0;
    bus.frame_ack = 1'b0;
    check_outputs();
  endtask

  task automatic do_reset();
    #2 reset = 1'b1;
    #1;
    m_capturing = 1'b0;
    m_have_line = 1'b0;
    m_ovr       = 1'b0;
    m_sync      = 1'b0;
    m_cnt       = 0;
    q.delete();
    check_outputs();
    check("rd_data_rst", bus.rd_data, 0);
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic read_check(input int addr);
    bus.rd_addr = addr[IDX_W-1:0];
    cyc(1'b0, 1'b0, 0, 1'b0);
    check($sformatf("rd_data[%0d]", addr), bus.rd_data, m_line[addr]);
  endtask

  function automatic int gen(input int mode, input int n);
    case (mode)
      0:       return n;
      1:       return int'($urandom_range(0, 255));
      2:       return 16;
      3:       return ((n == 40) || (n == 90)) ? 200 : 5;
      default: return int'($urandom_range(0, 15));
    endcase
  endfunction

  // Push n accepted pixels with random gaps and ignored ack pulses.
  task automatic pixels(input int mode, input int n);
    int k = 0;
    while (k < n) begin
      bit pv = ($urandom_range(0, 3) != 0);
      cyc(1'b0, pv, gen(mode, k), ($urandom_range(0, 7) == 0));
      if (pv) k++;
    end
  endtask

  task automatic capture_line(input int mode);
    cyc(1'b1, 1'b0, 0, 1'b0);
    pixels(mode, NUM_PIXELS);
  endtask

  initial begin
    bus.si = 1'b0; bus.pix_valid = 1'b0; bus.pix_data = '0;
    bus.frame_ack = 1'b0; bus.rd_addr = '0;
    @(posedge clk);
    #1;
    do_reset();
    $display("txn reset: checks=%0d", n_chk);

    // Basic line with data equal to index.
    for (int i = 0; i < 5; i++) cyc(1'b0, 1'b1, 99, 1'b0);
    capture_line(0);
    read_check(0); read_check(37); read_check(127);
    for (int i = 0; i < 5; i++) read_check(int'($urandom_range(0, NUM_PIXELS - 1)));
    $display("txn basic line: checks=%0d", n_chk);

    // Hold without ack; stray pixels must not disturb the frozen buffer.
    for (int i = 0; i < 500; i++) begin
      int a = int'($urandom_range(0, NUM_PIXELS - 1));
      bus.rd_addr = a[IDX_W-1:0];
      cyc(1'b0, ($urandom_range(0, 1) == 1), 255, 1'b0);
      check("rd_hold", bus.rd_data, m_line[a]);
    end
    cyc(1'b0, 1'b0, 0, 1'b1);
    $display("txn handshake: checks=%0d", n_chk);

    // Overrun while holding, then a fresh line after ack.
    capture_line(1);
    cyc(1'b1, 1'b0, 0, 1'b0);
    for (int i = 0; i < 8; i++) read_check(int'($urandom_range(0, NUM_PIXELS - 1)));
    cyc(1'b0, 1'b0, 0, 1'b1);
    capture_line(1);
    for (int i = 0; i < 8; i++) read_check(int'($urandom_range(0, NUM_PIXELS - 1)));
    // SI together with ack: line released but that SI does not start a line.
    cyc(1'b1, 1'b0, 0, 1'b1);
    for (int i = 0; i < 6; i++) cyc(1'b0, 1'b1, 77, 1'b0);
    capture_line(1);
    read_check(0); read_check(127);
    cyc(1'b0, 1'b0, 0, 1'b1);
    $display("txn overrun: checks=%0d", n_chk);

    // Resync: SI mid-line with a coincident pixel that must be dropped.
    cyc(1'b1, 1'b0, 0, 1'b0);
    pixels(1, 50);
    cyc(1'b1, 1'b1, 119, 1'b0);
    pixels(2, NUM_PIXELS);
    for (int i = 0; i < NUM_PIXELS; i++) read_check(i);
    cyc(1'b0, 1'b0, 0, 1'b1);
    $display("txn resync: checks=%0d", n_chk);

    // SI coincident with pix_valid from IDLE: that sample is absent.
    cyc(1'b1, 1'b1, 170, 1'b0);
    pixels(1, NUM_PIXELS);
    read_check(0); read_check(1);
    cyc(1'b0, 1'b0, 0, 1'b1);
    $display("txn coincidence: checks=%0d", n_chk);

    // Reset partway through a line.
    cyc(1'b1, 1'b0, 0, 1'b0);
    pixels(1, 60);
    do_reset();
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, 33, 1'b0);
    $display("txn mid-line reset: checks=%0d", n_chk);

    // Peak pattern with a tie, then random small values for more ties.
    capture_line(3);
    read_check(40); read_check(90);
    cyc(1'b0, 1'b0, 0, 1'b1);
    capture_line(4);
    for (int i = 0; i < 4; i++) read_check(int'($urandom_range(0, NUM_PIXELS - 1)));
    cyc(1'b0, 1'b0, 0, 1'b1);
    $display("txn peak: checks=%0d", n_chk);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
